// File: rtl/fetch_buffer_pkg.sv
// Shared fetch/decode definitions: datapath width, the NOP word shown when
// the queue is empty, and the layout of one queue entry so that every
// stage slices entries the same way.
package fetch_buffer_pkg;

  localparam int XLEN = 32;

  // Instruction word presented to decode when nothing is queued.
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Entry layout, MSB to LSB: {misaligned, pc, instr}
  localparam int ENTRY_W        = 2 * XLEN + 1;
  localparam int MISALIGNED_BIT = 2 * XLEN;
  localparam int PC_LSB         = XLEN;
  localparam int INSTR_LSB      = 0;

  // A PC is misaligned when it does not sit on a 4-byte boundary.
  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_buffer_mem.sv
// Entry storage for the fetch buffer.
// There is one write port. The read port is combinational, so the head entry
// appears in the same cycle that the read pointer moves. The array has no
// reset because occupancy is tracked entirely by the control logic.
module fetch_buffer_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Capture the incoming entry on an accepted push.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Elastic in-order instruction queue between fetch and decode.
// in_ready is computed only from registered occupancy, so there is no
// combinational path from out_ready. Flush wins over push and pop. When the
// queue is empty, the outputs are forced to zero so that decode sees a NOP.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = fetch_buffer_pkg::XLEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_instr,
  output logic                   out_misaligned,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;

  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // Push and pop are qualified by flush, so a flushing edge changes nothing
  // except clearing the queue.
  assign w_push  = in_valid & in_ready & ~flush;
  assign w_pop   = out_valid & out_ready & ~flush;
  assign w_wdata = {pc_misaligned(in_pc), in_pc, in_instr};

  fetch_buffer_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointer and occupancy bookkeeping. Pointers wrap naturally, and count
  // distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Present the head entry, or all zeros (the NOP word) while empty.
  always_comb begin
    out_pc         = '0;
    out_instr      = XLEN'(NOP_INSTR);
    out_misaligned = 1'b0;
    if (out_valid) begin
      out_pc         = w_rdata[PC_LSB +: XLEN];
      out_instr      = w_rdata[INSTR_LSB +: XLEN];
      out_misaligned = w_rdata[MISALIGNED_BIT];
    end
  end

endmodule
